// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one R-type instruction to the combinational vector ALU,
// holds its operands stable for a per-function number of cycles, then captures
// the ALU result into a valid/ready output buffer.
module alu_issue_ctrl #(
    parameter int LAT_SIMPLE = 1,
    parameter int LAT_MUL    = 2,
    parameter int LAT_LONG   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:63] in_rA,
    input  logic [0:63] in_rB,
    input  logic [0:5]  in_R_ins,
    input  logic [0:5]  in_Op_code,
    input  logic [0:1]  in_WW,
    output logic [0:63] alu_rA,
    output logic [0:63] alu_rB,
    output logic [0:5]  alu_R_ins,
    output logic [0:5]  alu_Op_code,
    output logic [0:1]  alu_WW,
    input  logic [0:63] alu_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] out_data,
    output logic        out_err,
    output logic        busy
);

    localparam logic [0:5] OP_RTYPE = 6'b101010;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       accept;
    logic       legal;
    logic       capture;

    // Only the R-type major opcode with function codes 1..18 reaches the ALU.
    function automatic logic is_legal(input logic [0:5] op, input logic [0:5] fn);
        return (op == OP_RTYPE) && (fn >= 6'd1) && (fn <= 6'd18);
    endfunction

    // Hold time minus one: the counter is loaded at accept and the capture
    // happens on the edge where it has already reached zero.
    function automatic logic [3:0] hold_minus1(input logic [0:5] fn);
        case (fn)
            6'b001000, 6'b001001, 6'b010000, 6'b010001: return 4'(LAT_MUL - 1);
            6'b001110, 6'b001111, 6'b010010:            return 4'(LAT_LONG - 1);
            default:                                    return 4'(LAT_SIMPLE - 1);
        endcase
    endfunction

    // A finishing result may be handed off and replaced on the same edge.
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign legal     = is_legal(in_Op_code, in_R_ins);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Next-state and hold-counter logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if (legal) begin
                        state_nxt = EXEC;
                        cnt_nxt   = hold_minus1(in_R_ins);
                    end else begin
                        state_nxt = DONE;
                    end
                end else if ((state == DONE) && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            EXEC: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and hold counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ALU operand registers: loaded only by a legal accept, held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_rA      <= '0;
            alu_rB      <= '0;
            alu_R_ins   <= '0;
            alu_Op_code <= '0;
            alu_WW      <= '0;
        end else if (accept && legal) begin
            alu_rA      <= in_rA;
            alu_rB      <= in_rB;
            alu_R_ins   <= in_R_ins;
            alu_Op_code <= in_Op_code;
            alu_WW      <= in_WW;
        end
    end

    // Output buffer: ALU result at end of hold, or an error marker for illegal input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data <= '0;
            out_err  <= 1'b0;
        end else if (capture) begin
            out_data <= alu_out;
            out_err  <= 1'b0;
        end else if (accept && !legal) begin
            out_data <= '0;
            out_err  <= 1'b1;
        end
    end

endmodule
